// File: rtl/prog_loader.sv
// Framed byte-stream loader: reassembles {opcode, data} words from COUNT/HI/LO.../CHK
// frames, writes them to instruction memory and holds the CPU until a clean load.
module prog_loader #(
  parameter int WIDTH      = 13,
  parameter int IWIDTH     = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [7:0]            IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  output logic [WIDTH-1:0]      IMEM_DATA,
  output logic                  IMEM_WE,
  output logic                  CPU_HOLD,
  output logic                  DONE,
  output logic                  ERR,
  output logic [ADDR_WIDTH-1:0] WORD_CNT
);

  localparam int DWIDTH = WIDTH - IWIDTH;
  // One extra bit so a count of exactly 2^ADDR_WIDTH words is representable.
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d;
  logic [CW-1:0]         n_q, n_d;
  logic [7:0]            xor_q, xor_d;
  logic [IWIDTH-1:0]     opcode_q, opcode_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [WIDTH-1:0]      imem_data_q, imem_data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic accept;
  logic count_bad;
  logic hi_bad;
  logic last_word;

  assign accept    = IN_VALID & in_ready_q;
  assign count_bad = (IN_DATA == 8'd0) ||
                     ({24'd0, IN_DATA} > (32'd1 << ADDR_WIDTH));
  assign hi_bad    = (IN_DATA[7:IWIDTH] != '0);
  assign last_word = !((word_cnt_q + CW'(1)) < n_q);

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    n_d         = n_q;
    xor_d       = xor_q;
    opcode_d    = opcode_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) begin
          state_d    = S_COUNT;
          word_cnt_d = '0;
          xor_d      = 8'd0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          xor_d   = IN_DATA;
          n_d     = CW'(IN_DATA);
          state_d = count_bad ? S_ERR : S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          xor_d = xor_q ^ IN_DATA;
          if (hi_bad) begin
            state_d = S_ERR;
          end else begin
            opcode_d = IN_DATA[IWIDTH-1:0];
            state_d  = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          xor_d       = xor_q ^ IN_DATA;
          imem_we_d   = 1'b1;
          imem_addr_d = word_cnt_q[ADDR_WIDTH-1:0];
          imem_data_d = {opcode_q, IN_DATA[DWIDTH-1:0]};
          if (word_cnt_q < n_q) begin
            word_cnt_d = word_cnt_q + CW'(1);
          end
          state_d = last_word ? S_CHK : S_HI;
        end
      end
      S_CHK: begin
        if (accept) begin
          state_d = (xor_q == IN_DATA) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the next-state decode.
    in_ready_d = (state_d == S_COUNT) || (state_d == S_HI) ||
                 (state_d == S_LO)    || (state_d == S_CHK);
    cpu_hold_d = in_ready_d || (state_d == S_ERR);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      n_q         <= '0;
      xor_q       <= 8'd0;
      opcode_q    <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      in_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      n_q         <= n_d;
      xor_q       <= xor_d;
      opcode_q    <= opcode_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      in_ready_q  <= in_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign IMEM_WE   = imem_we_q;
  assign IMEM_ADDR = imem_addr_q;
  assign IMEM_DATA = imem_data_q;
  assign CPU_HOLD  = cpu_hold_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign WORD_CNT  = word_cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table plus hand-written
// sequences for gapped input, mid-frame START and asynchronous reset.
module tb_prog_loader;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [7:0]  IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IMEM_ADDR;
  logic [12:0] IMEM_DATA;
  logic        IMEM_WE;
  logic        CPU_HOLD;
  logic        DONE;
  logic        ERR;
  logic [7:0]  WORD_CNT;

  int checks = 0;
  int errors = 0;

  prog_loader #(.WIDTH(13), .IWIDTH(5), .ADDR_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
    .IMEM_WE(IMEM_WE), .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERR(ERR),
    .WORD_CNT(WORD_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic [7:0]  addr;
    logic [12:0] wdata;
    logic        hold;
    logic        done;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  logic [7:0]  wr_addr[$];
  logic [12:0] wr_data[$];

  // Write monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (IMEM_WE && !RST) begin
      wr_addr.push_back(IMEM_ADDR);
      wr_data.push_back(IMEM_DATA);
    end
  end

  task automatic add(input logic s, input logic v, input logic [7:0] d,
                     input logic r, input logic w, input logic [7:0] a,
                     input logic [12:0] dt, input logic h, input logic dn,
                     input logic e, input logic [7:0] c);
    vec_t x;
    x.start = s; x.valid = v; x.data = d; x.ready = r; x.we = w; x.addr = a;
    x.wdata = dt; x.hold = h; x.done = dn; x.err = e; x.cnt = c;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    IN_VALID = 1'b0;
    repeat (gap) step();
    IN_DATA  = b;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
    step();
    IN_VALID = 1'b0;
    $display("byte 0x%02h sent after gap %0d", b, gap);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    logic [7:0] fr [6];
    fr[0] = 8'h02; fr[1] = 8'h0A; fr[2] = 8'h09;
    fr[3] = 8'h1F; fr[4] = 8'h2B; fr[5] = 8'h35;
    for (int i = 0; i < 6; i++) send_byte(fr[i], int'($urandom_range(0, max_gap)));
  endtask

  task automatic check_two_writes(input string tag);
    chk({tag, "_nwr"}, wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_a0"}, {24'd0, wr_addr[0]}, 32'd0);
      chk({tag, "_d0"}, {19'd0, wr_data[0]}, 32'h0A09);
      chk({tag, "_a1"}, {24'd0, wr_addr[1]}, 32'd1);
      chk({tag, "_d1"}, {19'd0, wr_data[1]}, 32'h1F2B);
    end
    chk({tag, "_done"}, {31'd0, DONE}, 32'd1);
    chk({tag, "_err"}, {31'd0, ERR}, 32'd0);
    chk({tag, "_hold"}, {31'd0, CPU_HOLD}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, WORD_CNT}, 32'd2);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; IN_DATA = 8'h00; IN_VALID = 1'b0;

    // Idle with a byte offered: nothing happens.
    add(0,1,8'h55, 0,0,8'h00,13'h0000,0,0,0,8'd0);
    // Good frame 02 0A 09 1F 2B 35.
    add(1,0,8'h00, 1,0,8'h00,13'h0000,1,0,0,8'd0);
    add(0,1,8'h02, 1,0,8'h00,13'h0000,1,0,0,8'd0);
    add(0,1,8'h0A, 1,0,8'h00,13'h0000,1,0,0,8'd0);
    add(0,1,8'h09, 1,1,8'h00,13'h0A09,1,0,0,8'd1);
    add(0,1,8'h1F, 1,0,8'h00,13'h0A09,1,0,0,8'd1);
    add(0,1,8'h2B, 1,1,8'h01,13'h1F2B,1,0,0,8'd2);
    add(0,1,8'h35, 0,0,8'h01,13'h1F2B,0,1,0,8'd2);
    add(0,1,8'h55, 0,0,8'h01,13'h1F2B,0,1,0,8'd2);
    // Same frame, bad checksum 34.
    add(1,0,8'h00, 1,0,8'h01,13'h1F2B,1,0,0,8'd0);
    add(0,1,8'h02, 1,0,8'h01,13'h1F2B,1,0,0,8'd0);
    add(0,1,8'h0A, 1,0,8'h01,13'h1F2B,1,0,0,8'd0);
    add(0,1,8'h09, 1,1,8'h00,13'h0A09,1,0,0,8'd1);
    add(0,1,8'h1F, 1,0,8'h00,13'h0A09,1,0,0,8'd1);
    add(0,1,8'h2B, 1,1,8'h01,13'h1F2B,1,0,0,8'd2);
    add(0,1,8'h34, 0,0,8'h01,13'h1F2B,1,0,1,8'd2);
    // Recovery: one-word frame 01 03 44 46.
    add(1,0,8'h00, 1,0,8'h01,13'h1F2B,1,0,0,8'd0);
    add(0,1,8'h01, 1,0,8'h01,13'h1F2B,1,0,0,8'd0);
    add(0,1,8'h03, 1,0,8'h01,13'h1F2B,1,0,0,8'd0);
    add(0,1,8'h44, 1,1,8'h00,13'h0344,1,0,0,8'd1);
    add(0,1,8'h46, 0,0,8'h00,13'h0344,0,1,0,8'd1);
    // HI byte with nonzero upper bits.
    add(1,0,8'h00, 1,0,8'h00,13'h0344,1,0,0,8'd0);
    add(0,1,8'h01, 1,0,8'h00,13'h0344,1,0,0,8'd0);
    add(0,1,8'hE0, 0,0,8'h00,13'h0344,1,0,1,8'd0);
    add(0,1,8'h0A, 0,0,8'h00,13'h0344,1,0,1,8'd0);
    // COUNT of zero.
    add(1,0,8'h00, 1,0,8'h00,13'h0344,1,0,0,8'd0);
    add(0,1,8'h00, 0,0,8'h00,13'h0344,1,0,1,8'd0);

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", {31'd0, IN_READY}, 32'd0);
    chk("rst_we",    {31'd0, IMEM_WE},  32'd0);
    chk("rst_hold",  {31'd0, CPU_HOLD}, 32'd0);
    chk("rst_flags", {30'd0, DONE, ERR}, 32'd0);
    chk("rst_bus",   {3'd0, IMEM_ADDR, IMEM_DATA, WORD_CNT}, 32'd0);
    RST = 1'b0;
    step();

    foreach (vecs[i]) begin
      START    = vecs[i].start;
      IN_VALID = vecs[i].valid;
      IN_DATA  = vecs[i].data;
      step();
      chk($sformatf("vec%0d_ready", i), {31'd0, IN_READY}, {31'd0, vecs[i].ready});
      chk($sformatf("vec%0d_we", i),    {31'd0, IMEM_WE},  {31'd0, vecs[i].we});
      chk($sformatf("vec%0d_addr", i),  {24'd0, IMEM_ADDR}, {24'd0, vecs[i].addr});
      chk($sformatf("vec%0d_data", i),  {19'd0, IMEM_DATA}, {19'd0, vecs[i].wdata});
      chk($sformatf("vec%0d_hold", i),  {31'd0, CPU_HOLD}, {31'd0, vecs[i].hold});
      chk($sformatf("vec%0d_done", i),  {31'd0, DONE},     {31'd0, vecs[i].done});
      chk($sformatf("vec%0d_err", i),   {31'd0, ERR},      {31'd0, vecs[i].err});
      chk($sformatf("vec%0d_cnt", i),   {24'd0, WORD_CNT}, {24'd0, vecs[i].cnt});
      $display("vec %0d: start=%0d valid=%0d data=%02h -> rdy=%0d we=%0d a=%02h d=%04h hold=%0d done=%0d err=%0d cnt=%0d",
               i, vecs[i].start, vecs[i].valid, vecs[i].data, IN_READY, IMEM_WE,
               IMEM_ADDR, IMEM_DATA, CPU_HOLD, DONE, ERR, WORD_CNT);
    end
    START = 1'b0; IN_VALID = 1'b0;
    step();

    // Gapped frame with a START pulse injected mid-frame.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h02, 2);
    send_byte(8'h0A, 0);
    pulse_start();
    send_byte(8'h09, 3);
    send_byte(8'h1F, 5);
    send_byte(8'h2B, 1);
    send_byte(8'h35, 4);
    check_two_writes("gap");

    // Reset between first LO and second HI.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h0A, 0);
    send_byte(8'h09, 0);
    #1 RST = 1'b1;
    #1;
    chk("amid_ready", {31'd0, IN_READY}, 32'd0);
    chk("amid_we",    {31'd0, IMEM_WE},  32'd0);
    chk("amid_hold",  {31'd0, CPU_HOLD}, 32'd0);
    chk("amid_cnt",   {24'd0, WORD_CNT}, 32'd0);
    step();
    RST = 1'b0;
    IN_DATA = 8'h1F; IN_VALID = 1'b1;
    repeat (5) step();
    IN_VALID = 1'b0;
    chk("post_rst_ready", {31'd0, IN_READY}, 32'd0);
    chk("post_rst_nwr", wr_addr.size(), 32'd0);
    $display("reset mid-load: writes=%0d ready=%0d hold=%0d", wr_addr.size(), IN_READY, CPU_HOLD);

    pulse_start();
    send_frame(0);
    check_two_writes("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
